// File: rtl/bn_pkg.sv
// Shared widths, the per-channel coefficient record and the round/saturate helper
// for the batch-normalisation pipeline.
package bn_pkg;

    localparam int BN_DIN_W  = 27;
    localparam int BN_COEF_W = 18;
    localparam int BN_DOUT_W = 9;
    localparam int BN_CH     = 8;
    localparam int BN_SHIFT  = 8;

    typedef struct packed {
        logic signed [BN_COEF_W-1:0] mu;
        logic signed [BN_COEF_W-1:0] delta;
        logic signed [BN_COEF_W-1:0] beta;
    } bn_coef_t;

    // Adds half an LSB, shifts arithmetically (floor), then clamps to the signed
    // dout_w range, so ties round towards +infinity and nothing is ever wrapped.
    function automatic logic signed [63:0] bn_round_sat(
        input logic signed [63:0] value,
        input int                 shift,
        input int                 dout_w
    );
        logic signed [63:0] scaled;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        scaled = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        hi     = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
        lo     = -(64'sd1 <<< (dout_w - 1));
        if (scaled > hi)
            return hi;
        else if (scaled < lo)
            return lo;
        return scaled;
    endfunction

endpackage

// File: rtl/bn_coef_bank.sv
// Per-channel coefficient register file: one write port, one asynchronous read
// port, every entry resetting to the identity transform.
module bn_coef_bank
    import bn_pkg::*;
#(
    parameter int CH    = BN_CH,
    parameter int CH_W  = (CH > 1) ? $clog2(CH) : 1,
    parameter int SHIFT = BN_SHIFT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [CH_W-1:0] i_wr_ch,
    input  bn_coef_t        i_wr_coef,
    input  logic [CH_W-1:0] i_rd_ch,
    output bn_coef_t        o_rd_coef
);

    localparam bn_coef_t COEF_IDENTITY = {{BN_COEF_W{1'b0}},
                                          BN_COEF_W'(1) << SHIFT,
                                          {BN_COEF_W{1'b0}}};

    bn_coef_t        r_bank [CH];
    logic [CH_W-1:0] w_rd_idx;
    logic            w_wr_ok;

    // Out-of-range reads fall back to entry 0; out-of-range writes are dropped.
    assign w_rd_idx  = (int'(i_rd_ch) < CH) ? i_rd_ch : '0;
    assign w_wr_ok   = i_we && (int'(i_wr_ch) < CH);
    assign o_rd_coef = r_bank[w_rd_idx];

    // NOTE: the bank is reset because identity coefficients must be live
    // immediately after reset; a RAM-style array without reset would not be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CH; k++)
                r_bank[k] <= COEF_IDENTITY;
        end else if (w_wr_ok) begin
            r_bank[i_wr_ch] <= i_wr_coef;
        end
    end

endmodule

// File: rtl/batch_norm_pipe.sv
// Three-stage batch-normalisation pipeline with valid/ready on both sides.
// Define BN_RELU_EN to fuse a ReLU clamp into the output stage.
module batch_norm_pipe
    import bn_pkg::*;
#(
    parameter int DIN_W  = BN_DIN_W,
    parameter int COEF_W = BN_COEF_W,
    parameter int DOUT_W = BN_DOUT_W,
    parameter int CH     = BN_CH,
    parameter int SHIFT  = BN_SHIFT,
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_we,
    input  logic        [CH_W-1:0]   coef_ch,
    input  logic signed [COEF_W-1:0] coef_mu,
    input  logic signed [COEF_W-1:0] coef_delta,
    input  logic signed [COEF_W-1:0] coef_beta,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DIN_W-1:0]  in_data,
    input  logic        [CH_W-1:0]   in_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DOUT_W-1:0] out_data,
    output logic        [CH_W-1:0]   out_ch
);

    localparam int D1_W = DIN_W + 1;
    localparam int P_W  = D1_W + COEF_W;
    localparam int S_W  = P_W + 1;

    bn_coef_t w_wr_coef;
    bn_coef_t w_rd_coef;

    logic                     r_v1, r_v2, r_v3;
    logic signed [D1_W-1:0]   r_d1;
    logic signed [COEF_W-1:0] r_delta1, r_beta1, r_beta2;
    logic signed [P_W-1:0]    r_p2;
    logic        [CH_W-1:0]   r_ch1, r_ch2, r_ch3;
    logic signed [DOUT_W-1:0] r_dout;

    logic                     w_en1, w_en2, w_en3;
    logic signed [D1_W-1:0]   w_d1;
    logic signed [P_W-1:0]    w_p;
    logic signed [S_W-1:0]    w_s;
    logic signed [DOUT_W-1:0] w_sat;
    logic signed [DOUT_W-1:0] w_dout;

    assign w_wr_coef = {coef_mu, coef_delta, coef_beta};

    bn_coef_bank #(
        .CH    (CH),
        .CH_W  (CH_W),
        .SHIFT (SHIFT)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_we      (coef_we),
        .i_wr_ch   (coef_ch),
        .i_wr_coef (w_wr_coef),
        .i_rd_ch   (in_ch),
        .o_rd_coef (w_rd_coef)
    );

    // A stage may load when its register is empty or its occupant moves on this cycle.
    assign w_en3     = !r_v3 || out_ready;
    assign w_en2     = !r_v2 || w_en3;
    assign w_en1     = !r_v1 || w_en2;
    assign in_ready  = w_en1;

    assign w_d1  = D1_W'(in_data) - D1_W'(w_rd_coef.mu);
    assign w_p   = P_W'(r_d1) * P_W'(r_delta1);
    assign w_s   = S_W'(r_p2) + S_W'(r_beta2);
    assign w_sat = DOUT_W'(bn_round_sat(64'(w_s), SHIFT, DOUT_W));

`ifdef BN_RELU_EN
    assign w_dout = w_sat[DOUT_W-1] ? '0 : w_sat;
`else
    assign w_dout = w_sat;
`endif

    assign out_valid = r_v3;
    assign out_data  = r_dout;
    assign out_ch    = r_ch3;

    // NOTE: pipeline state uses non-blocking assignments so every stage samples
    // the previous stage's value from before this edge, regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_d1     <= '0;
            r_delta1 <= '0;
            r_beta1  <= '0;
            r_beta2  <= '0;
            r_p2     <= '0;
            r_ch1    <= '0;
            r_ch2    <= '0;
            r_ch3    <= '0;
            r_dout   <= '0;
        end else begin
            if (w_en1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_d1     <= w_d1;
                    r_delta1 <= w_rd_coef.delta;
                    r_beta1  <= w_rd_coef.beta;
                    r_ch1    <= in_ch;
                end
            end
            if (w_en2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_p2    <= w_p;
                    r_beta2 <= r_beta1;
                    r_ch2   <= r_ch1;
                end
            end
            if (w_en3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_dout <= w_dout;
                    r_ch3  <= r_ch2;
                end
            end
        end
    end

endmodule

// File: tb/tb_batch_norm_pipe.sv
// Scoreboard bench for batch_norm_pipe: expected results are queued as samples
// are accepted and compared in order as results leave the pipeline.
module tb_batch_norm_pipe;

    localparam int DIN_W  = 27;
    localparam int COEF_W = 18;
    localparam int DOUT_W = 9;
    localparam int CH     = 8;
    localparam int SHIFT  = 8;
    localparam int CH_W   = 3;

`ifdef BN_RELU_EN
    localparam longint EXP_NEG300 = 0;
    localparam longint EXP_NEG3   = 0;
`else
    localparam longint EXP_NEG300 = -256;
    localparam longint EXP_NEG3   = -1;
`endif

    typedef struct {
        longint data;
        int     ch;
        int     in_cyc;
    } sb_entry_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     coef_we;
    logic        [CH_W-1:0]   coef_ch;
    logic signed [COEF_W-1:0] coef_mu, coef_delta, coef_beta;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DIN_W-1:0]  in_data;
    logic        [CH_W-1:0]   in_ch;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DOUT_W-1:0] out_data;
    logic        [CH_W-1:0]   out_ch;

    batch_norm_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .coef_we    (coef_we),
        .coef_ch    (coef_ch),
        .coef_mu    (coef_mu),
        .coef_delta (coef_delta),
        .coef_beta  (coef_beta),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ch      (in_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch)
    );

    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_errors = 0;
    int        cyc      = 0;
    bit        chk_lat  = 1'b1;
    sb_entry_t sb[$];
    int        out_cyc_q[$];
    longint    m_mu[CH], m_delta[CH], m_beta[CH];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: exact integer arithmetic with floor division done by hand.
    function automatic longint model(input longint din, input int ch);
        longint v, q, den, hi, lo;
        den = longint'(1) << SHIFT;
        v   = (din - m_mu[ch]) * m_delta[ch] + m_beta[ch] + (den / 2);
        q   = v / den;
        if (v < 0 && (v % den) != 0)
            q = q - 1;
        hi = (longint'(1) << (DOUT_W - 1)) - 1;
`ifdef BN_RELU_EN
        lo = 0;
`else
        lo = -(longint'(1) << (DOUT_W - 1));
`endif
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                m_mu[k]    <= 0;
                m_delta[k] <= longint'(1) << SHIFT;
                m_beta[k]  <= 0;
            end
        end else if (coef_we && int'(coef_ch) < CH) begin
            m_mu[coef_ch]    <= longint'(coef_mu);
            m_delta[coef_ch] <= longint'(coef_delta);
            m_beta[coef_ch]  <= longint'(coef_beta);
        end
    end

    task automatic push_exp(input longint exp, input int ch);
        sb_entry_t e;
        e.data   = exp;
        e.ch     = ch;
        e.in_cyc = cyc;
        sb.push_back(e);
    endtask

    // Output side: compare every transfer, and demand a frozen payload while stalled.
    logic signed [DOUT_W-1:0] held_data;
    logic        [CH_W-1:0]   held_ch;
    bit                       held_v = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", longint'(out_data), 9999);
                end else begin
                    sb_entry_t e;
                    e = sb.pop_front();
                    check("out_data", longint'(out_data), e.data);
                    check("out_ch", longint'(out_ch), longint'(e.ch));
                    if (chk_lat)
                        check("latency", longint'(cyc - e.in_cyc), 3);
                    out_cyc_q.push_back(cyc);
                end
            end
            if (out_valid && !out_ready) begin
                if (held_v) begin
                    check("stall_hold_data", longint'(out_data), longint'(held_data));
                    check("stall_hold_ch", longint'(out_ch), longint'(held_ch));
                end
                held_data = out_data;
                held_ch   = out_ch;
                held_v    = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic send(input longint din, input int ch, input longint exp,
                        input bit use_model, output int waited);
        in_valid = 1'b1;
        in_data  = DIN_W'(din);
        in_ch    = CH_W'(ch);
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (in_ready)
            push_exp(use_model ? model(din, ch) : exp, ch);
        else
            check("send_timeout", longint'(waited), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input int ch, input longint mu, input longint delta, input longint beta);
        coef_we    = 1'b1;
        coef_ch    = CH_W'(ch);
        coef_mu    = COEF_W'(mu);
        coef_delta = COEF_W'(delta);
        coef_beta  = COEF_W'(beta);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0)
            check("drain_timeout", longint'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, acc, base, n;
        rst = 1'b1; coef_we = 1'b0; coef_ch = '0; coef_mu = '0; coef_delta = '0; coef_beta = '0;
        in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_ch", longint'(out_ch), 0);
        @(posedge clk); #1;

        // Identity bank on ch0, isolated samples
        send(100, 0, 100, 0, w);        drain();
        send(300, 0, 255, 0, w);        drain();
        send(-300, 0, EXP_NEG300, 0, w); drain();

        // Scaled channel, then with beta
        write_coef(1, 10, 512, 0);
        send(20, 1, 20, 0, w);          drain();
        write_coef(1, 10, 512, 256);
        send(20, 1, 21, 0, w);          drain();

        // Round half up
        write_coef(2, 0, 128, 0);
        send(3, 2, 2, 0, w);            drain();
        send(-3, 2, EXP_NEG3, 0, w);    drain();

        // Back-to-back stream, alternating ch0/ch1
        base = out_cyc_q.size();
        for (int i = 0; i < 10; i++) begin
            send(longint'(i * 37 - 150), i % 2, 0, 1, w);
            check("stream_in_ready", longint'(w), 0);
        end
        drain();
        check("stream_count", longint'(out_cyc_q.size() - base), 10);
        if (out_cyc_q.size() >= base + 10)
            check("stream_span", longint'(out_cyc_q[base + 9] - out_cyc_q[base]), 9);

        // Downstream stall under continuous input
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = DIN_W'(40 * acc - 90);
            in_ch   = CH_W'(acc % 2);
            @(negedge clk);
            if (in_ready) begin
                push_exp(model(longint'(40 * acc - 90), acc % 2), acc % 2);
                acc++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stall_accepted", longint'(acc), 3);
        check("stall_in_ready", longint'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (acc < 6 && n < 30) begin
            in_data = DIN_W'(40 * acc - 90);
            in_ch   = CH_W'(acc % 2);
            @(negedge clk);
            if (in_ready) begin
                push_exp(model(longint'(40 * acc - 90), acc % 2), acc % 2);
                acc++;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("recover_accepted", longint'(acc), 6);
        drain();
        chk_lat = 1'b1;

        // Same-cycle coefficient write: entering sample sees the old delta
        coef_we = 1'b1; coef_ch = '0; coef_mu = '0; coef_delta = COEF_W'(512); coef_beta = '0;
        send(100, 0, 100, 0, w);
        coef_we = 1'b0;
        check("wr_same_cycle_accept", longint'(w), 0);
        send(100, 0, 200, 0, w);
        drain();

        // Reset with samples in flight
        out_ready = 1'b0;
        send(50, 0, 0, 1, w);
        send(60, 0, 0, 1, w);
        @(posedge clk); #1;
        check("pre_rst_out_valid", longint'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("rst_flush_out_valid", longint'(out_valid), 0);
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_quiet", longint'(out_valid), 0);
        end
        @(posedge clk); #1;
        send(100, 0, 100, 0, w);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (checks %0d)", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
